cmd_proc_rx: RTL and testbench
==============================

# cmd_proc_rx

Receive-side command frame parser for the GTX 16-bit link. It watches the word stream (RX_DATA, RXCTRL) for 32-word command frames delimited by 0x02BC comma/idle characters. It checks each frame's header, checksum and tail. For every frame that passes the 0x2410/0x1984 header it raises a one-cycle CMD pulse with a 2-bit classification; the camera/host control FSM consumes this to sequence configuration and acknowledgement.

## Interface
- No parameters. Fixed constants: word width 16, frame length 32 words.
- clk  input  1  single system clock; all logic on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- RX_DATA  input  16  received word, valid every clock.
- RXCTRL  input  2  per-word control. 2'b00 = data word. 2'b01 = K-character word; the only legal K-word is 0x02BC (idle/comma).
- CMD  output  1  one-cycle pulse: a frame was completed or aborted.
- CMD_Type  output  2  frame classification, valid while CMD=1; holds last value otherwise.

## Operation
- Frame layout, data words, word index k = 0..31:
  - k0 = 0x2410, k1 = 0x1984 (header).
  - k2 = sequence number; k3 = frame type (0x0001 = configuration); k4 = length (0x0018, not checked).
  - k5..k28 = payload.
  - k29 = checksum: low 16 bits of the sum of k2..k28 (27 words), carries discarded.
  - k30 = 0xDBEF, k31 = 0xE67B (tail).
- Idle stream between frames: RX_DATA=0x02BC, RXCTRL=01. Any number of idle words is allowed, including none.
- States:
  - HUNT (reset): wait for a data word equal to 0x2410 → HDR. All other words are ignored.
  - HDR: data word 0x1984 → BODY, with counter k=2 and checksum cleared. Any other word → HUNT silently. A second 0x2410 stays in HDR.
  - BODY: capture words k=2..31.
    - Accumulate k2..k28 into a 16-bit wrap-around sum.
    - Latch the type word at k3.
    - Compare k29 with the sum. Compare k30 and k31 with the tail constants.
    - After k31 → HUNT and emit CMD.
    - If any word with RXCTRL≠00 arrives in BODY, abort: emit CMD with type 00 and go to HUNT. An abort on the 0x02BC K-word does not consume a header.
- CMD_Type encoding:
  - 00 = rejected frame: checksum mismatch, tail mismatch, or abort.
  - 01 = valid frame, type word 0x0001 (configuration).
  - 10 = valid frame, type word 0x0002 (data).
  - 11 = valid frame, any other type word.
- RXCTRL values 10 and 11 are treated like 01: not data.

## Timing
- Inputs are sampled on the rising edge of clk.
- CMD is registered. It is high for exactly one cycle, the cycle after the edge that samples k31 (or the aborting word).
- Latency from the k31 sample to CMD is 1 clock.
- Back-to-back frames are supported: a 0x2410 sampled in the same cycle that CMD is high starts a new frame.
- Reset values: CMD=0, CMD_Type=2'b00, state HUNT, counter 0, sum 0.
- Reset asserted mid-frame discards the partial frame and no CMD is emitted. After release the block hunts for a fresh header.

## Structure
- Shared package holds:
  - Header constants 0x2410 and 0x1984.
  - Tail constants 0xDBEF and 0xE67B.
  - Idle constant 0x02BC.
  - Frame length 32; checksum index 29.
  - Type codes 0x0001 and 0x0002.
  - CMD_Type encodings.
- Implement as one module with no sub-modules. A 5-bit word counter, a 16-bit accumulator and a 3-state FSM are sufficient.

## Test plan
- Valid configuration frame (seq 0, seconds 0x10, microseconds 0x12, star time 0x10, frequency 0x1, spot time 0x18, correct checksum), framed by 0x02BC idles → one CMD pulse, CMD_Type=01, exactly 1 clock after k31.
- Same frame with k29 incremented by 1 → CMD pulse, CMD_Type=00.
- Frame whose k31 is 0xE67A → CMD_Type=00.
- 0x02BC/RXCTRL=01 injected at k10 → CMD pulse with CMD_Type=00 on the next cycle. A following valid frame is then accepted with CMD_Type=01.
- 0x2410 followed by 0x1985, or continuous idle only → no CMD.
- Two valid frames back-to-back, type 0x0002 then 0x0005 → two pulses, CMD_Type=10 then 11. Reset asserted at k15 of a third frame → no pulse.

Source files
------------

// File: rtl/cmd_proc_rx_pkg.sv
// Shared constants and helpers for the GTX receive-side command frame parser.
package cmd_proc_rx_pkg;

  localparam int          WORD_W     = 16;
  localparam int          FRAME_LEN  = 32;

  localparam logic [15:0] HDR0_WORD  = 16'h2410;
  localparam logic [15:0] HDR1_WORD  = 16'h1984;
  localparam logic [15:0] TAIL0_WORD = 16'hDBEF;
  localparam logic [15:0] TAIL1_WORD = 16'hE67B;
  localparam logic [15:0] IDLE_WORD  = 16'h02BC;

  localparam logic [15:0] TYPE_CONFIG = 16'h0001;
  localparam logic [15:0] TYPE_DATA   = 16'h0002;

  // Word indices within a frame; the body starts right after the two header words.
  localparam logic [4:0]  BODY_IDX  = 5'd2;
  localparam logic [4:0]  TYPE_IDX  = 5'd3;
  localparam logic [4:0]  CSUM_IDX  = 5'd29;
  localparam logic [4:0]  TAIL0_IDX = 5'd30;
  localparam logic [4:0]  LAST_IDX  = 5'd31;

  typedef enum logic [1:0] {
    CMD_REJECT = 2'b00,
    CMD_CONFIG = 2'b01,
    CMD_DATA   = 2'b10,
    CMD_OTHER  = 2'b11
  } cmd_type_e;

  typedef enum logic [1:0] {
    ST_HUNT = 2'b00,
    ST_HDR  = 2'b01,
    ST_BODY = 2'b10
  } state_e;

  function automatic cmd_type_e classify(input logic [15:0] type_word);
    cmd_type_e res;
    case (type_word)
      TYPE_CONFIG: res = CMD_CONFIG;
      TYPE_DATA:   res = CMD_DATA;
      default:     res = CMD_OTHER;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/cmd_proc_rx_if.sv
// Word stream from the GTX receiver and the resulting command pulse.
interface cmd_proc_rx_if;
  logic [15:0] RX_DATA;
  logic [1:0]  RXCTRL;
  logic        CMD;
  logic [1:0]  CMD_Type;

  modport master (output RX_DATA, output RXCTRL, input CMD, input CMD_Type);
  modport slave  (input RX_DATA, input RXCTRL, output CMD, output CMD_Type);
endinterface

// File: rtl/cmd_proc_rx.sv
// Command frame parser: hunts for the 0x2410/0x1984 header, checks checksum and
// tail, and emits a one-cycle CMD pulse with a 2-bit classification.
module cmd_proc_rx
  import cmd_proc_rx_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  cmd_proc_rx_if.slave  rx
);

  state_e      state_r;
  logic [4:0]  cnt_r;
  logic [15:0] sum_r;
  logic [15:0] type_r;
  logic        bad_r;
  logic        cmd_r;
  logic [1:0]  cmd_type_r;

  logic        is_data_s;
  logic [15:0] word_s;

  assign is_data_s   = (rx.RXCTRL == 2'b00);
  assign word_s      = rx.RX_DATA;
  assign rx.CMD      = cmd_r;
  assign rx.CMD_Type = cmd_type_r;

  // Frame FSM with word counter, checksum accumulator and registered CMD outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_HUNT;
      cnt_r      <= 5'd0;
      sum_r      <= 16'h0000;
      type_r     <= 16'h0000;
      bad_r      <= 1'b0;
      cmd_r      <= 1'b0;
      cmd_type_r <= CMD_REJECT;
    end else begin
      cmd_r <= 1'b0;
      case (state_r)
        ST_HUNT: begin
          if (is_data_s && (word_s == HDR0_WORD)) begin
            state_r <= ST_HDR;
          end else begin
            state_r <= ST_HUNT;
          end
        end
        ST_HDR: begin
          if (is_data_s && (word_s == HDR1_WORD)) begin
            state_r <= ST_BODY;
            cnt_r   <= BODY_IDX;
            sum_r   <= 16'h0000;
            bad_r   <= 1'b0;
          end else if (is_data_s && (word_s == HDR0_WORD)) begin
            state_r <= ST_HDR;
          end else begin
            state_r <= ST_HUNT;
          end
        end
        ST_BODY: begin
          if (!is_data_s) begin
            // Any control word inside a frame aborts it; the word itself is dropped.
            cmd_r      <= 1'b1;
            cmd_type_r <= CMD_REJECT;
            cnt_r      <= 5'd0;
            state_r    <= ST_HUNT;
          end else if (cnt_r == LAST_IDX) begin
            cmd_r   <= 1'b1;
            cnt_r   <= 5'd0;
            state_r <= ST_HUNT;
            if (bad_r || (word_s != TAIL1_WORD)) begin
              cmd_type_r <= CMD_REJECT;
            end else begin
              cmd_type_r <= classify(type_r);
            end
          end else begin
            cnt_r <= cnt_r + 5'd1;
            if (cnt_r < CSUM_IDX) begin
              sum_r <= sum_r + word_s;
            end else if (cnt_r == CSUM_IDX) begin
              bad_r <= bad_r | (word_s != sum_r);
            end else begin
              bad_r <= bad_r | (word_s != TAIL0_WORD);
            end
            if (cnt_r == TYPE_IDX) begin
              type_r <= word_s;
            end else begin
              type_r <= type_r;
            end
          end
        end
        default: begin
          state_r <= ST_HUNT;
          cnt_r   <= 5'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cmd_proc_rx.sv
// Directed bench for cmd_proc_rx: valid, corrupted, aborted, back-to-back and reset-interrupted frames.
module tb_cmd_proc_rx;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   pulses = 0;
  int   p0;
  logic [15:0] frame [32];

  cmd_proc_rx_if bus ();

  cmd_proc_rx dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rx    (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [15:0] d, input logic [1:0] c);
    bus.RX_DATA = d;
    bus.RXCTRL  = c;
    @(posedge clk);
    #1;
    if (bus.CMD === 1'b1) pulses++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send(16'h02BC, 2'b01);
  endtask

  task automatic send_range(input int lo, input int hi);
    for (int k = lo; k <= hi; k++) send(frame[k], 2'b00);
  endtask

  // Payload fields: seq 0, length 0x18, seconds 0x10, usec 0x12, star 0x10, freq 0x1, spot 0x18.
  task automatic build(input logic [15:0] typ, input logic [15:0] csum);
    for (int k = 0; k < 32; k++) frame[k] = 16'h0000;
    frame[0]  = 16'h2410;
    frame[1]  = 16'h1984;
    frame[2]  = 16'h0000;
    frame[3]  = typ;
    frame[4]  = 16'h0018;
    frame[5]  = 16'h0010;
    frame[6]  = 16'h0012;
    frame[7]  = 16'h0010;
    frame[8]  = 16'h0001;
    frame[9]  = 16'h0018;
    frame[29] = csum;
    frame[30] = 16'hDBEF;
    frame[31] = 16'hE67B;
  endtask

  function automatic logic [15:0] cmd16();
    return {15'd0, bus.CMD};
  endfunction

  function automatic logic [15:0] typ16();
    return {14'd0, bus.CMD_Type};
  endfunction

  initial begin
    rst_n       = 1'b0;
    bus.RX_DATA = 16'h02BC;
    bus.RXCTRL  = 2'b01;
    repeat (3) @(posedge clk);
    #1;
    check("reset_cmd", cmd16(), 16'd0);
    check("reset_type", typ16(), 16'd0);
    rst_n = 1'b1;
    idle(4);
    check("idle_no_pulse", 16'(pulses), 16'd0);

    // Valid configuration frame: checksum 0x0064.
    build(16'h0001, 16'h0064);
    send_range(0, 30);
    check("cfg_before_k31", cmd16(), 16'd0);
    send_range(31, 31);
    check("cfg_cmd", cmd16(), 16'd1);
    check("cfg_type", typ16(), 16'd1);
    idle(1);
    check("cfg_one_cycle", cmd16(), 16'd0);
    check("cfg_type_hold", typ16(), 16'd1);
    check("cfg_pulse_count", 16'(pulses), 16'd1);

    // Checksum off by one.
    build(16'h0001, 16'h0065);
    send_range(0, 31);
    check("csum_cmd", cmd16(), 16'd1);
    check("csum_type", typ16(), 16'd0);
    idle(2);

    // Bad last tail word.
    build(16'h0001, 16'h0064);
    frame[31] = 16'hE67A;
    send_range(0, 31);
    check("tail_cmd", cmd16(), 16'd1);
    check("tail_type", typ16(), 16'd0);
    idle(2);

    // Idle K-word at k10 aborts, then a good frame is accepted.
    build(16'h0001, 16'h0064);
    send_range(0, 9);
    send(16'h02BC, 2'b01);
    check("abort_cmd", cmd16(), 16'd1);
    check("abort_type", typ16(), 16'd0);
    idle(1);
    check("abort_one_cycle", cmd16(), 16'd0);
    send_range(0, 31);
    check("post_abort_cmd", cmd16(), 16'd1);
    check("post_abort_type", typ16(), 16'd1);
    idle(2);
    check("pulse_total", 16'(pulses), 16'd5);

    // Broken second header word and long idle run.
    p0 = pulses;
    send(16'h2410, 2'b00);
    send(16'h1985, 2'b00);
    send_range(2, 31);
    idle(40);
    check("bad_hdr_no_pulse", 16'(pulses), 16'(p0));

    // Back-to-back frames of type 0x0002 and 0x0005.
    p0 = pulses;
    build(16'h0002, 16'h0065);
    send_range(0, 31);
    check("b2b_first_cmd", cmd16(), 16'd1);
    check("b2b_first_type", typ16(), 16'd2);
    build(16'h0005, 16'h0068);
    send_range(0, 31);
    check("b2b_second_cmd", cmd16(), 16'd1);
    check("b2b_second_type", typ16(), 16'd3);
    check("b2b_pulse_count", 16'(pulses - p0), 16'd2);

    // Reset at k15 of a third frame.
    p0 = pulses;
    build(16'h0001, 16'h0064);
    send_range(0, 14);
    bus.RX_DATA = frame[15];
    bus.RXCTRL  = 2'b00;
    rst_n       = 1'b0;
    #2;
    check("mid_reset_cmd", cmd16(), 16'd0);
    check("mid_reset_type", typ16(), 16'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    send_range(16, 31);
    idle(3);
    check("mid_reset_no_pulse", 16'(pulses), 16'(p0));
    send_range(0, 31);
    check("recover_cmd", cmd16(), 16'd1);
    check("recover_type", typ16(), 16'd1);
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
